mode_select_text_gen: RTL and testbench
=======================================

MODE_SELECT_TEXT_GEN -- requirements
Module: mode_select_text_gen

Interface
REQ-001 SHALL have parameter X0, 256, left pixel column of the 16-character text strip.
REQ-002 SHALL have parameter Y0, 224, top pixel row of the text strip.
REQ-003 SHALL have parameter TEXT_RGB, 12'hFFF, colour driven for lit text pixels.
REQ-004 SHALL have port clk  input  1  system pixel clock; single clock domain.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pixel_x  input  10  current pixel column from VGA sync.
REQ-007 SHALL have port pixel_y  input  10  current pixel row from VGA sync.
REQ-008 SHALL have port video_on  input  1  visible-area flag from VGA sync.
REQ-009 SHALL have port frame_tick  input  1  one-clock pulse per frame.
REQ-010 SHALL have port char_xy  output  8  address to mode-select character ROM.
REQ-011 SHALL have port char_code  input  7  ASCII code returned combinationally by character ROM.
REQ-012 SHALL have port font_addr  output  11  address to font ROM, {char_code, row[3:0]}.
REQ-013 SHALL have port font_word  input  8  font ROM row data, valid one clock after font_addr (synchronous ROM), MSB = leftmost pixel.
REQ-014 SHALL have port text_on  output  1  registered: current delayed pixel is lit text.
REQ-015 SHALL have port text_rgb  output  12  registered: TEXT_RGB when text_on, else 12'h000.

Function
REQ-016 SHALL compute in_region = video_on AND X0 <= pixel_x < X0+128 AND Y0 <= pixel_y < Y0+16; widths 10-bit unsigned, no wrap.
REQ-017 SHALL drive char_xy = {4'h0, (pixel_x-X0)[6:3]} when in_region, else 8'h00 (combinational).
REQ-018 SHALL drive font_addr = {char_code, (pixel_y-Y0)[3:0]} when in_region, else {7'h20, 4'h0} (blank).
REQ-019 SHALL register stage-1 pipeline: in_region_d1, bit_col_d1 = (pixel_x-X0)[2:0], col_d1 = (pixel_x-X0)[6:3], aligned with font_word.
REQ-020 SHALL compute lit = in_region_d1 AND font_word[7-bit_col_d1] AND NOT (blink_off AND col_d1 >= 10).
REQ-021 SHALL register text_on <= lit and text_rgb <= lit ? TEXT_RGB : 12'h000; total latency pixel input -> output = 2 clocks.
REQ-022 SHALL keep a 5-bit blink counter incrementing on frame_tick, wrapping 31 -> 0; blink_off = counter[4] (16 frames on, 16 off).
REQ-023 SHALL treat frame_tick coincident with an in-region pixel with no pipeline disturbance; blink state takes effect on the next clock.
REQ-024 SHALL produce text_on = 0 for pixels with video_on = 0 even if coordinates fall inside the strip.
REQ-025 SHALL apply blinking only to columns 10..15 ("SELECT"); columns 0..9 always steady.

Reset
REQ-026 SHALL, on reset_n low, asynchronously clear text_on, text_rgb, in_region_d1, bit_col_d1, col_d1 and blink counter to 0.
REQ-027 SHALL, on reset asserted mid-line, output text_on = 0 from the reset edge and resume valid output 2 clocks after the first in-region pixel following release.

Structure
REQ-028 SHALL place CHAR_W = 8, CHAR_H = 16, STRIP_CHARS = 16, BLANK code 7'h20 and blink column threshold 10 in the shared pong display package.
REQ-029 SHALL instantiate no sub-module; character ROM and font ROM are external, connected at the display top level; blink counter is a natural optional sub-module named blink_counter.

Verification
REQ-030 SHALL verify: pixel (256,224), video_on=1, char_code 'M' (7'h4D), font_word 8'h80 -> font_addr 11'h4D0, text_on=1, text_rgb=12'hFFF exactly 2 clocks later.
REQ-031 SHALL verify: pixel (263,224) with font_word 8'h80 -> text_on=0 (bit 0 column); font_word 8'h01 -> text_on=1.
REQ-032 SHALL verify: pixel (336,230) (column 10, 'S') with blink counter 16 -> text_on=0; counter 15 -> follows font bit.
REQ-033 SHALL verify: pixels (255,224), (384,224), (256,240), and (256,224) with video_on=0 -> char_xy=8'h00, text_on=0.
REQ-034 SHALL verify: 32 frame_tick pulses from reset -> counter wraps to 0, blink_off cycles 0->1->0.
REQ-035 SHALL verify: reset_n pulsed low mid-strip -> text_on/text_rgb 0 immediately (asynchronous), correct output resumes 2 clocks after release.

Source files
------------

// File: rtl/mode_select_text_gen_pkg.sv
// rtl/mode_select_text_gen_pkg.sv - shared geometry and blink constants for the mode-select text strip
package mode_select_text_gen_pkg;

  localparam int         CHAR_W      = 8;
  localparam int         CHAR_H      = 16;
  localparam int         STRIP_CHARS = 16;
  localparam int         STRIP_W     = CHAR_W * STRIP_CHARS;
  localparam logic [6:0] BLANK_CODE  = 7'h20;
  localparam logic [3:0] BLINK_COL   = 4'd10;

  // Columns from BLINK_COL upward ("SELECT") are hidden during the off half of the blink period
  function automatic logic blink_masked(input logic blink_off, input logic [3:0] col);
    return blink_off && (col >= BLINK_COL);
  endfunction

endpackage

// File: rtl/mode_select_text_gen_blink_counter.sv
// rtl/mode_select_text_gen_blink_counter.sv - 5-bit frame counter, blink_off is its MSB (16 frames on, 16 off)
module blink_counter (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  output logic blink_off
);

  logic [4:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 5'd0;
    end else if (tick) begin
      cnt <= cnt + 5'd1;
    end
  end

  assign blink_off = cnt[4];

endmodule

// File: rtl/mode_select_text_gen.sv
// rtl/mode_select_text_gen.sv - 16-character text strip renderer with blinking "SELECT" field
module mode_select_text_gen
  import mode_select_text_gen_pkg::*;
#(
  parameter int         X0       = 256,
  parameter int         Y0       = 224,
  parameter logic [11:0] TEXT_RGB = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_tick,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_word,
  output logic        text_on,
  output logic [11:0] text_rgb
);

  // Bounds compared at 11 bits so a strip placed near the screen edge cannot wrap
  localparam logic [10:0] X_LO  = 11'(X0);
  localparam logic [10:0] X_HI  = 11'(X0 + STRIP_W);
  localparam logic [10:0] Y_LO  = 11'(Y0);
  localparam logic [10:0] Y_HI  = 11'(Y0 + CHAR_H);
  localparam logic [6:0]  X_LO7 = 7'(X0);
  localparam logic [3:0]  Y_LO4 = 4'(Y0);

  logic       in_region;
  logic [6:0] dx;
  logic [3:0] dy;
  logic       in_region_d1;
  logic [2:0] bit_col_d1;
  logic [3:0] col_d1;
  logic       blink_off;
  logic       lit;

  // Low bits of the offset only depend on low bits of the operands
  assign dx = pixel_x[6:0] - X_LO7;
  assign dy = pixel_y[3:0] - Y_LO4;

  assign in_region = video_on
                  && ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI)
                  && ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);

  assign char_xy   = in_region ? {4'h0, dx[6:3]} : 8'h00;
  assign font_addr = in_region ? {char_code, dy} : {BLANK_CODE, 4'h0};

  blink_counter u_blink (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (frame_tick),
    .blink_off (blink_off)
  );

  // Stage 1 lines pixel position up with the synchronous font ROM output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_region_d1 <= 1'b0;
      bit_col_d1   <= 3'd0;
      col_d1       <= 4'd0;
    end else begin
      in_region_d1 <= in_region;
      bit_col_d1   <= dx[2:0];
      col_d1       <= dx[6:3];
    end
  end

  assign lit = in_region_d1 && font_word[3'd7 - bit_col_d1]
            && !blink_masked(blink_off, col_d1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      text_on  <= 1'b0;
      text_rgb <= 12'h000;
    end else begin
      text_on  <= lit;
      text_rgb <= lit ? TEXT_RGB : 12'h000;
    end
  end

endmodule

// File: tb/tb_mode_select_text_gen.sv
// tb/tb_mode_select_text_gen.sv - directed self-checking bench for mode_select_text_gen
module tb_mode_select_text_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_tick;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_word;
  logic        text_on;
  logic [11:0] text_rgb;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        r_on;
  logic        r_mid;
  logic [11:0] r_rgb;
  logic [7:0]  r_cxy;
  logic [10:0] r_fa;

  mode_select_text_gen #(.X0(256), .Y0(224), .TEXT_RGB(12'hFFF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .char_xy    (char_xy),
    .char_code  (char_code),
    .font_addr  (font_addr),
    .font_word  (font_word),
    .text_on    (text_on),
    .text_rgb   (text_rgb)
  );

  always #5 clk = ~clk;

  // One in-region pixel for a single clock, font data supplied one clock later
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic von,
                     input logic [7:0] fw, input logic [6:0] cc);
    @(negedge clk);
    pixel_x = x; pixel_y = y; video_on = von; char_code = cc;
    #1;
    r_cxy = char_xy;
    r_fa  = font_addr;
    @(posedge clk);
    #1;
    r_mid = text_on;
    pixel_x = 10'd0; pixel_y = 10'd0; font_word = fw;
    @(posedge clk);
    #1;
    r_on  = text_on;
    r_rgb = text_rgb;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b1;
    #1;
    total_cnt++;
    if (text_on !== 1'b0) $display("FAIL reset_text_on: got %b expected 0", text_on); else pass_cnt++;
    total_cnt++;
    if (text_rgb !== 12'h000) $display("FAIL reset_text_rgb: got %h expected 000", text_rgb); else pass_cnt++;
    total_cnt++;
    if (char_xy !== 8'h00) $display("FAIL reset_char_xy: got %h expected 00", char_xy); else pass_cnt++;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_basic();
    pix(10'd256, 10'd224, 1'b1, 8'h80, 7'h4D);
    total_cnt++;
    if (r_cxy !== 8'h00) $display("FAIL basic_char_xy: got %h expected 00", r_cxy); else pass_cnt++;
    total_cnt++;
    if (r_fa !== 11'h4D0) $display("FAIL basic_font_addr: got %h expected 4d0", r_fa); else pass_cnt++;
    total_cnt++;
    if (r_mid !== 1'b0) $display("FAIL basic_latency1: got %b expected 0", r_mid); else pass_cnt++;
    total_cnt++;
    if (r_on !== 1'b1) $display("FAIL basic_text_on: got %b expected 1", r_on); else pass_cnt++;
    total_cnt++;
    if (r_rgb !== 12'hFFF) $display("FAIL basic_text_rgb: got %h expected fff", r_rgb); else pass_cnt++;
  endtask

  task automatic test_bit_col();
    pix(10'd263, 10'd224, 1'b1, 8'h80, 7'h4D);
    total_cnt++;
    if (r_on !== 1'b0) $display("FAIL bit7_msb_off: got %b expected 0", r_on); else pass_cnt++;
    total_cnt++;
    if (r_rgb !== 12'h000) $display("FAIL bit7_rgb: got %h expected 000", r_rgb); else pass_cnt++;
    pix(10'd263, 10'd224, 1'b1, 8'h01, 7'h4D);
    total_cnt++;
    if (r_on !== 1'b1) $display("FAIL bit7_lsb_on: got %b expected 1", r_on); else pass_cnt++;
    pix(10'd300, 10'd227, 1'b1, 8'h08, 7'h41);
    total_cnt++;
    if (r_cxy !== 8'h05) $display("FAIL col5_char_xy: got %h expected 05", r_cxy); else pass_cnt++;
    total_cnt++;
    if (r_fa !== 11'h413) $display("FAIL col5_font_addr: got %h expected 413", r_fa); else pass_cnt++;
    total_cnt++;
    if (r_on !== 1'b1) $display("FAIL col5_bit4_on: got %b expected 1", r_on); else pass_cnt++;
  endtask

  task automatic test_region();
    logic [9:0] xs [4] = '{10'd255, 10'd384, 10'd256, 10'd256};
    logic [9:0] ys [4] = '{10'd224, 10'd224, 10'd240, 10'd224};
    logic       vs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pix(xs[i], ys[i], vs[i], 8'hFF, 7'h4D);
      total_cnt++;
      if (r_cxy !== 8'h00) $display("FAIL region%0d_char_xy: got %h expected 00", i, r_cxy); else pass_cnt++;
      total_cnt++;
      if (r_fa !== 11'h200) $display("FAIL region%0d_font_addr: got %h expected 200", i, r_fa); else pass_cnt++;
      total_cnt++;
      if (r_on !== 1'b0) $display("FAIL region%0d_text_on: got %b expected 0", i, r_on); else pass_cnt++;
    end
    pix(10'd383, 10'd239, 1'b1, 8'h01, 7'h54);
    total_cnt++;
    if (r_cxy !== 8'h0F) $display("FAIL corner_char_xy: got %h expected 0f", r_cxy); else pass_cnt++;
    total_cnt++;
    if (r_fa !== 11'h54F) $display("FAIL corner_font_addr: got %h expected 54f", r_fa); else pass_cnt++;
    total_cnt++;
    if (r_on !== 1'b1) $display("FAIL corner_text_on: got %b expected 1", r_on); else pass_cnt++;
  endtask

  task automatic test_blink();
    do_reset();
    ticks(15);
    pix(10'd336, 10'd230, 1'b1, 8'h80, 7'h53);
    total_cnt++;
    if (r_cxy !== 8'h0A) $display("FAIL blink15_char_xy: got %h expected 0a", r_cxy); else pass_cnt++;
    total_cnt++;
    if (r_fa !== 11'h536) $display("FAIL blink15_font_addr: got %h expected 536", r_fa); else pass_cnt++;
    total_cnt++;
    if (r_on !== 1'b1) $display("FAIL blink15_col10_on: got %b expected 1", r_on); else pass_cnt++;
    ticks(1);
    pix(10'd336, 10'd230, 1'b1, 8'h80, 7'h53);
    total_cnt++;
    if (r_on !== 1'b0) $display("FAIL blink16_col10_off: got %b expected 0", r_on); else pass_cnt++;
    total_cnt++;
    if (r_rgb !== 12'h000) $display("FAIL blink16_col10_rgb: got %h expected 000", r_rgb); else pass_cnt++;
    pix(10'd328, 10'd224, 1'b1, 8'h80, 7'h20);
    total_cnt++;
    if (r_on !== 1'b1) $display("FAIL blink16_col9_steady: got %b expected 1", r_on); else pass_cnt++;
    pix(10'd383, 10'd224, 1'b1, 8'h01, 7'h54);
    total_cnt++;
    if (r_on !== 1'b0) $display("FAIL blink16_col15_off: got %b expected 0", r_on); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    ticks(16);
    pix(10'd336, 10'd224, 1'b1, 8'h80, 7'h53);
    total_cnt++;
    if (r_on !== 1'b0) $display("FAIL wrap16_off: got %b expected 0", r_on); else pass_cnt++;
    ticks(15);
    pix(10'd336, 10'd224, 1'b1, 8'h80, 7'h53);
    total_cnt++;
    if (r_on !== 1'b0) $display("FAIL wrap31_off: got %b expected 0", r_on); else pass_cnt++;
    ticks(1);
    pix(10'd336, 10'd224, 1'b1, 8'h80, 7'h53);
    total_cnt++;
    if (r_on !== 1'b1) $display("FAIL wrap32_on: got %b expected 1", r_on); else pass_cnt++;
  endtask

  task automatic test_tick_coincident();
    do_reset();
    ticks(15);
    @(negedge clk);
    pixel_x = 10'd256; pixel_y = 10'd224; video_on = 1'b1; char_code = 7'h4D; frame_tick = 1'b1;
    #1;
    total_cnt++;
    if (font_addr !== 11'h4D0) $display("FAIL tick_font_addr: got %h expected 4d0", font_addr); else pass_cnt++;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0; font_word = 8'h80;
    @(posedge clk);
    #1;
    total_cnt++;
    if (text_on !== 1'b1) $display("FAIL tick_col0_on: got %b expected 1", text_on); else pass_cnt++;
    pix(10'd336, 10'd224, 1'b1, 8'h80, 7'h53);
    total_cnt++;
    if (r_on !== 1'b0) $display("FAIL tick_then_col10_off: got %b expected 0", r_on); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    pixel_x = 10'd256; pixel_y = 10'd224; video_on = 1'b1; char_code = 7'h4D;
    @(posedge clk);
    #1;
    pixel_x = 10'd257; font_word = 8'h80;
    @(posedge clk);
    #1;
    total_cnt++;
    if (text_on !== 1'b1) $display("FAIL b2b_first_on: got %b expected 1", text_on); else pass_cnt++;
    pixel_x = 10'd0; font_word = 8'hBF;
    @(posedge clk);
    #1;
    total_cnt++;
    if (text_on !== 1'b0) $display("FAIL b2b_second_off: got %b expected 0", text_on); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (text_on !== 1'b0) $display("FAIL b2b_after_off: got %b expected 0", text_on); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    pixel_x = 10'd256; pixel_y = 10'd224; video_on = 1'b1; char_code = 7'h4D; font_word = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (text_on !== 1'b1) $display("FAIL areset_pre_on: got %b expected 1", text_on); else pass_cnt++;
    #1;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (text_on !== 1'b0) $display("FAIL areset_async_on: got %b expected 0", text_on); else pass_cnt++;
    total_cnt++;
    if (text_rgb !== 12'h000) $display("FAIL areset_async_rgb: got %h expected 000", text_rgb); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (text_on !== 1'b0) $display("FAIL areset_resume1: got %b expected 0", text_on); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (text_on !== 1'b1) $display("FAIL areset_resume2_on: got %b expected 1", text_on); else pass_cnt++;
    total_cnt++;
    if (text_rgb !== 12'hFFF) $display("FAIL areset_resume2_rgb: got %h expected fff", text_rgb); else pass_cnt++;
    pixel_x = 10'd0; pixel_y = 10'd0;
  endtask

  initial begin
    reset_n    = 1'b0;
    pixel_x    = 10'd0;
    pixel_y    = 10'd0;
    video_on   = 1'b0;
    frame_tick = 1'b0;
    char_code  = 7'h20;
    font_word  = 8'h00;
    test_reset();
    test_basic();
    test_bit_col();
    test_region();
    test_blink();
    test_wrap();
    test_tick_coincident();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
